// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit:
// FSM state encoding, datapath mux encodings, opcode/condition constants
// and the condition-code evaluation helper.
package multicycle_pkg;

    // FSM states; FETCH must be zero so the reset state reads back as 0.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Register-file write-back / PC source select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Instruction class, Instr[27:26]
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    // Data-processing command, funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALUControl encoding
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Condition field, Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // NZCV flags, bit order matches ALUFlags
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Raw (ungated) per-state controls produced by the FSM
    typedef struct packed {
        logic       next_pc;
        logic       branch;
        logic       reg_w;
        logic       mem_w;
        logic       ir_write;
        logic       alu_op;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
    } ctrl_t;

    // Evaluate a condition field against the stored flags; 1111 never executes.
    function automatic logic cond_check(input logic [3:0] cond, input flags_t f);
        logic ok;
        logic ge;
        ge = (f.n == f.v);
        ok = 1'b0;
        case (cond)
            COND_EQ: ok = f.z;
            COND_NE: ok = ~f.z;
            COND_CS: ok = f.c;
            COND_CC: ok = ~f.c;
            COND_MI: ok = f.n;
            COND_PL: ok = ~f.n;
            COND_VS: ok = f.v;
            COND_VC: ok = ~f.v;
            COND_HI: ok = f.c & ~f.z;
            COND_LS: ok = ~f.c | f.z;
            COND_GE: ok = ge;
            COND_LT: ok = ~ge;
            COND_GT: ok = ~f.z & ge;
            COND_LE: ok = f.z | ~ge;
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition unit: holds the NZCV flags register, evaluates the current
// instruction's condition in DECODE and latches the result (CondEx) so the
// rest of the instruction sees a stable decision even if flags change.
module cond_unit
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_cond,        // Instr[31:28]
    input  logic [3:0] i_alu_flags,   // NZCV from the ALU
    input  logic [1:0] i_flag_w,      // [1] loads N,Z; [0] loads C,V
    input  logic       i_flag_en,     // high in EXECUTER/EXECUTEI
    input  logic       i_cond_latch,  // high in DECODE
    output logic       o_cond_ex
);

    flags_t r_flags;
    logic   r_cond_ex;
    logic   w_cond_now;

    // Condition check against the flags as they stand right now
    always_comb begin
        w_cond_now = cond_check(i_cond, r_flags);
    end

    // Flags register: partial updates, only for instructions that execute
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_flags <= '0;
        end else if (i_flag_en && r_cond_ex) begin
            if (i_flag_w[1]) begin
                r_flags.n <= i_alu_flags[3];
                r_flags.z <= i_alu_flags[2];
            end
            if (i_flag_w[0]) begin
                r_flags.c <= i_alu_flags[1];
                r_flags.v <= i_alu_flags[0];
            end
        end
    end

    // CondEx latch: captured once per instruction at the end of DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond_ex <= 1'b0;
        end else if (i_cond_latch) begin
            r_cond_ex <= w_cond_now;
        end
    end

    assign o_cond_ex = r_cond_ex;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller: FSM sequencing the shared datapath, ALU decoder,
// and the condition-gated write enables. Flags and CondEx live in cond_unit.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic         clk,
    input  logic         reset,       // asynchronous, active-low
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUControl,
    output logic [3:0]   State
);

    // Instruction fields
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_unused_rn;

    assign w_cond      = Instr[31:28];
    assign w_op        = Instr[27:26];
    assign w_funct     = Instr[25:20];
    assign w_rd        = Instr[15:12];
    assign w_cmd       = w_funct[4:1];
    assign w_s         = w_funct[0];
    // Rn selects a register in the datapath; the controller never looks at it.
    assign w_unused_rn = ^Instr[19:16];

    state_e     r_state;
    state_e     w_next_state;
    ctrl_t      w_ctrl;
    logic [1:0] w_alu_control;
    logic [1:0] w_flag_w;
    logic       w_no_write;
    logic       w_cond_ex;
    logic       w_pcs;

    // State register; reset aborts any instruction and returns to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and raw per-state controls
    always_comb begin
        // NOTE: every output of this block gets a default up front, so no
        // path through the case can leave a value held (no latches).
        w_next_state = S_FETCH;
        w_ctrl       = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.adr_src    = 1'b0;
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.next_pc    = 1'b1;
                w_next_state      = S_DECODE;
            end
            S_DECODE: begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.result_src = RES_ALURESULT;
                case (w_op)
                    OP_MEM:    w_next_state = S_MEMADR;
                    OP_DP:     w_next_state = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BRANCH: w_next_state = S_BRANCH;
                    OP_NOP:    w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_next_state     = w_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_ctrl.adr_src = 1'b1;
                w_next_state   = S_MEMWB;
            end
            S_MEMWB: begin
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_w      = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_MEMWR: begin
                w_ctrl.adr_src = 1'b1;
                w_ctrl.mem_w   = 1'b1;
                w_next_state   = S_FETCH;
            end
            S_EXECUTER: begin
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = 1'b1;
                w_next_state     = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = 1'b1;
                w_next_state     = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_w      = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a  = 1'b0;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.result_src = RES_ALURESULT;
                w_ctrl.branch     = 1'b1;
                w_next_state      = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // ALU decoder: operation and flag-write mask for data-processing commands
    always_comb begin
        w_alu_control = ALU_ADD;
        w_flag_w      = 2'b00;
        if (w_ctrl.alu_op) begin
            case (w_cmd)
                CMD_ADD: begin
                    w_alu_control = ALU_ADD;
                    w_flag_w      = w_s ? 2'b11 : 2'b00;
                end
                CMD_SUB: begin
                    w_alu_control = ALU_SUB;
                    w_flag_w      = w_s ? 2'b11 : 2'b00;
                end
                CMD_AND: begin
                    w_alu_control = ALU_AND;
                    w_flag_w      = w_s ? 2'b10 : 2'b00;
                end
                CMD_ORR: begin
                    w_alu_control = ALU_ORR;
                    w_flag_w      = w_s ? 2'b10 : 2'b00;
                end
                CMD_CMP: begin
                    w_alu_control = ALU_SUB;
                    w_flag_w      = w_s ? 2'b11 : 2'b00;
                end
                default: begin
                    w_alu_control = ALU_ADD;
                    w_flag_w      = 2'b00;
                end
            endcase
        end
    end

    // CMP suppresses the register write-back. It must still hold in ALUWB,
    // where ALUOp is low, so it is decoded straight from the instruction and
    // restricted to data-processing ops so load/store offsets cannot alias it.
    assign w_no_write = (w_op == OP_DP) && (w_cmd == CMD_CMP);

    cond_unit u_cond_unit (
        .clk          (clk),
        .rst_n        (reset),
        .i_cond       (w_cond),
        .i_alu_flags  (ALUFlags),
        .i_flag_w     (w_flag_w),
        .i_flag_en    ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)),
        .i_cond_latch (r_state == S_DECODE),
        .o_cond_ex    (w_cond_ex)
    );

    // NOTE: the write enables are also gated by reset itself, so nothing can
    // pulse in the window where reset is low but a clock edge still arrives.
    assign w_pcs    = ((w_rd == 4'hF) & w_ctrl.reg_w) | w_ctrl.branch;
    assign PCWrite  = reset & (w_ctrl.next_pc | (w_pcs & w_cond_ex));
    assign RegWrite = reset & w_ctrl.reg_w & w_cond_ex & ~w_no_write;
    assign MemWrite = reset & w_ctrl.mem_w & w_cond_ex;
    assign IRWrite  = reset & w_ctrl.ir_write;

    assign AdrSrc     = w_ctrl.adr_src;
    assign ALUSrcA    = w_ctrl.alu_src_a;
    assign ALUSrcB    = w_ctrl.alu_src_b;
    assign ResultSrc  = w_ctrl.result_src;
    assign ALUControl = w_alu_control;
    assign ImmSrc     = w_op;
    assign RegSrc     = {w_op == OP_MEM, w_op == OP_BRANCH};
    assign State      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller. Each record is one
// clock cycle: the Instr/ALUFlags to drive and the full expected output set.
module tb_multicycle_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]   ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0]   State;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    always #5 clk = ~clk;

    // exp = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
    //        ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl}
    typedef struct {
        logic [31:12] instr;
        logic [3:0]   flags;
        logic [19:0]  exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [19:0] observe();
        return {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h (state got %0d want %0d, en got %04b want %04b)",
                     name, got, exp, got[19:16], exp[19:16], got[15:12], exp[15:12]);
        end
    endtask

    task automatic add(input logic [31:12] instr, input logic [3:0] flags, input logic [3:0] st,
                       input logic pcw, input logic memw, input logic regw, input logic irw,
                       input logic adr, input logic srca, input logic [1:0] srcb,
                       input logic [1:0] res, input logic [1:0] imm, input logic [1:0] rs,
                       input logic [1:0] alu);
        vec_t v;
        v.instr = instr;
        v.flags = flags;
        v.exp   = {st, pcw, memw, regw, irw, adr, srca, srcb, res, imm, rs, alu};
        vecs.push_back(v);
    endtask

    // FETCH and DECODE cycles, identical for every instruction apart from ImmSrc/RegSrc
    task automatic fd(input logic [31:12] instr, input logic [1:0] imm, input logic [1:0] rs);
        add(instr, 4'h0, 4'd0, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, imm, rs, 2'b00);
        add(instr, 4'h0, 4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, imm, rs, 2'b00);
    endtask

    // Data-processing: EXECUTER (st 6) or EXECUTEI (st 7), then ALUWB
    task automatic dp(input logic [31:12] instr, input logic [3:0] flags, input logic [3:0] st,
                      input logic [1:0] srcb, input logic [1:0] alu, input logic regw);
        fd(instr, 2'b00, 2'b00);
        add(instr, flags, st,   0, 0, 0,    0, 0, 0, srcb,  2'b00, 2'b00, 2'b00, alu);
        add(instr, 4'h0,  4'd8, 0, 0, regw, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic br(input logic [31:12] instr, input logic pcw);
        fd(instr, 2'b10, 2'b01);
        add(instr, 4'h0, 4'd9, pcw, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00);
    endtask

    task automatic ldr(input logic [31:12] instr, input logic pcw);
        fd(instr, 2'b01, 2'b10);
        add(instr, 4'h0, 4'd2, 0,   0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00);
        add(instr, 4'h0, 4'd3, 0,   0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
        add(instr, 4'h0, 4'd4, pcw, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00);
    endtask

    task automatic str(input logic [31:12] instr);
        fd(instr, 2'b01, 2'b10);
        add(instr, 4'h0, 4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00);
        add(instr, 4'h0, 4'd5, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    endtask

    task automatic apply_now(input vec_t v, input string name);
        Instr    = v.instr;
        ALUFlags = v.flags;
        #1;
        check(name, observe(), v.exp);
    endtask

    initial begin
        vec_t rv;
        // Flag trace in comments is NZCV after the instruction completes.
        dp(20'hE0821, 4'b1111, 4'd6, 2'b00, 2'b00, 1);  // ADD, S=0: flags stay 0000
        dp(20'h00821, 4'b0000, 4'd6, 2'b00, 2'b00, 0);  // ADDEQ, Z=0: no write
        dp(20'hE3500, 4'b0100, 4'd7, 2'b01, 2'b01, 0);  // CMP #0: 0100, NoWrite
        br(20'h0A000, 1);                               // BEQ taken
        br(20'h1A000, 0);                               // BNE not taken
        ldr(20'hE5910, 0);                              // LDR R0
        str(20'hE5810);                                 // STR
        ldr(20'hE591F, 1);                              // LDR PC
        dp(20'hE0921, 4'b0010, 4'd6, 2'b00, 2'b00, 1);  // ADDS: 0010
        dp(20'h00921, 4'b0100, 4'd6, 2'b00, 2'b00, 0);  // ADDSEQ fails: stays 0010
        br(20'h2A000, 1);                               // BCS taken
        br(20'h0A000, 0);                               // BEQ not taken
        dp(20'hE1921, 4'b1001, 4'd6, 2'b00, 2'b11, 1);  // ORRS: N,Z only -> 1010
        br(20'h4A000, 1);                               // BMI taken
        br(20'h6A000, 0);                               // BVS not taken (V kept 0)
        dp(20'hE0421, 4'b0000, 4'd6, 2'b00, 2'b01, 1);  // SUB
        dp(20'hE0021, 4'b0000, 4'd6, 2'b00, 2'b10, 1);  // AND
        fd(20'hEC000, 2'b11, 2'b00);                    // op=11: FETCH, DECODE only

        // Reset held from time zero
        reset    = 1'b0;
        Instr    = 20'hE0821;
        ALUFlags = 4'h0;
        @(negedge clk);
        #1 check("rst_init", observe(), {4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00});
        @(negedge clk);
        #1 check("rst_init_hold", observe(), {4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_now(vecs[i], $sformatf("vec%0d_%05h", i, vecs[i].instr));
            @(negedge clk);
        end

        // Reset in MEMRD: must abort at once, and flags/CondEx must clear.
        // The first FETCH also confirms the op=11 instruction returned to FETCH.
        vecs.delete();
        ldr(20'hE5910, 0);
        for (int i = 0; i < 3; i++) begin
            apply_now(vecs[i], $sformatf("mid_ldr%0d", i));
            @(negedge clk);
        end
        apply_now(vecs[3], "mid_ldr_memrd");
        reset = 1'b0;
        #1 check("rst_async", observe(), {4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00});
        @(negedge clk);
        #1 check("rst_hold", observe(), {4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00});
        @(negedge clk);
        reset = 1'b1;
        // BCS after reset: C was 1 before, must read 0 now -> not taken
        vecs.delete();
        br(20'h2A000, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            rv = vecs[i];
            apply_now(rv, $sformatf("post_rst%0d", i));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
